pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encodings, NOP value and counter sizing.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } hz_state_e;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TMO_W = 8;

    localparam logic [TMO_W-1:0] TIMEOUT_LIMIT = 8'd255;
    // Value the ID/EX register takes when idex_bubble is asserted.
    localparam logic [31:0]      NOP_INSTR     = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             back_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
               ex_branch_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, back_en, state,
               stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
               ex_branch_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_bubble, back_en, state,
               stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Parameterised-width event counter that sticks at all-ones.
module hazard_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes and
// data-memory waits, with event counters and a sticky memory-wait timeout.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e        state_d, state_q;
    logic             pend_br_d, pend_br_q;
    logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic             tmo_d, tmo_q;

    logic load_use;
    logic branch;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, back_en;

    always_comb begin
        load_use = hz.ex_memread && (hz.ex_rd != '0) && (state_q != ST_STALL) &&
                   ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                    (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
        // A branch seen while memory was busy is replayed once memory frees up.
        branch      = hz.ex_branch_taken || pend_br_q;

        state_d     = ST_RUN;
        pend_br_d   = pend_br_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        back_en     = 1'b1;

        if (hz.mem_busy) begin
            state_d   = ST_WAIT;
            pend_br_d = branch;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            back_en   = 1'b0;
        end else if (branch) begin
            state_d     = ST_FLUSH;
            pend_br_d   = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            state_d     = ST_STALL;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            back_en     = 1'b0;
        end
    end

    always_comb begin
        tmo_cnt_d = '0;
        if (hz.mem_busy) begin
            tmo_cnt_d = (tmo_cnt_q == TIMEOUT_LIMIT) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
        tmo_d = tmo_q || (tmo_cnt_d == TIMEOUT_LIMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pend_br_q <= 1'b0;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_br_q <= pend_br_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    hazard_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   ((state_d == ST_STALL) || (state_d == ST_WAIT)),
        .count (hz.stall_cnt)
    );

    hazard_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (state_d == ST_FLUSH),
        .count (hz.flush_cnt)
    );

    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.back_en     = back_en;
    assign hz.state       = state_q;
    assign hz.mem_timeout = tmo_q;

endmodule
